// File: rtl/fresh_bitmap_engine_if.sv
// Host-side bus of fresh_bitmap_engine: range push, ID queries, count command/result and status.
interface fresh_bitmap_engine_if #(
  parameter int ADDR_W = 17,
  parameter int CNT_W  = ADDR_W + 1
);
  logic              range_valid;
  logic              range_ready;
  logic [ADDR_W-1:0] range_low;
  logic [ADDR_W-1:0] range_high;
  logic              range_fresh;
  logic              query_valid;
  logic              query_ready;
  logic [ADDR_W-1:0] query_addr;
  logic              resp_valid;
  logic              resp_fresh;
  logic              cmd_count;
  logic              count_valid;
  logic [CNT_W-1:0]  count_value;
  logic              busy;
  logic              err_order;

  modport master (
    output range_valid, range_low, range_high, range_fresh, query_valid, query_addr, cmd_count,
    input  range_ready, query_ready, resp_valid, resp_fresh, count_valid, count_value, busy, err_order
  );
  modport slave (
    input  range_valid, range_low, range_high, range_fresh, query_valid, query_addr, cmd_count,
    output range_ready, query_ready, resp_valid, resp_fresh, count_valid, count_value, busy, err_order
  );
endinterface

// File: rtl/fresh_bitmap_engine.sv
// Word-wide freshness bitmap: FIFO-buffered range painting, pipelined single-ID queries and a
// full-map popcount sweep, all sharing one synchronous-read RAM.
module fresh_bitmap_engine #(
  parameter int ADDR_W     = 17,
  parameter int WORD_W     = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = ADDR_W + 1
) (
  input logic                  clk,
  input logic                  rst_n,
  fresh_bitmap_engine_if.slave bus
);
  localparam int OFF_W  = $clog2(WORD_W);
  localparam int NWORDS = (1 << ADDR_W) / WORD_W;
  localparam int WA_W   = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int FA_W   = $clog2(FIFO_DEPTH);
  localparam int STAGES = 2;

  typedef struct packed {
    logic [ADDR_W-1:0] low;
    logic [ADDR_W-1:0] high;
    logic              fresh;
  } range_t;

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_FILL, S_COUNT} state_t;

  function automatic logic [WA_W-1:0] word_of(input logic [ADDR_W-1:0] a);
    return WA_W'(a >> OFF_W);
  endfunction

  state_t            state, state_nx;
  logic [WORD_W-1:0] mem [NWORDS];
  logic [WORD_W-1:0] rd_q, wr_data, mask, merged;
  logic [WA_W-1:0]   rd_addr, wr_addr, ptr, wa, last_word;
  logic              rd_en, wr_en, rd_done, wpend, pop, push, finish_cnt;
  logic [OFF_W-1:0]  lb, hb;
  logic [CNT_W-1:0]  acc, popcnt, count_q;
  logic              pending, err_q, count_vld_q;
  range_t            cur;

  // range FIFO, pointers carry one wrap bit to tell full from empty
  range_t          fifo_mem [FIFO_DEPTH];
  logic [FA_W:0]   fwp, frp;
  logic            fifo_empty, fifo_full;
  range_t          head;

  assign fifo_empty = (fwp == frp);
  assign fifo_full  = (fwp[FA_W] != frp[FA_W]) && (fwp[FA_W-1:0] == frp[FA_W-1:0]);
  assign head       = fifo_mem[frp[FA_W-1:0]];
  assign push       = bus.range_valid && bus.range_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fwp <= '0;
      frp <= '0;
    end else begin
      if (push) fwp <= fwp + 1'b1;
      if (pop)  frp <= frp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[fwp[FA_W-1:0]] <= range_t'{bus.range_low, bus.range_high, bus.range_fresh};
  end

  // query pipeline: RAM read, bit select, output register
  logic [STAGES:0]  vld_pipe;
  logic [OFF_W-1:0] q_off;
  logic             q_bit, resp_bit, q_acc;

  assign bus.query_ready = (state == S_IDLE) && fifo_empty && !pending;
  assign q_acc           = bus.query_valid && bus.query_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      q_off    <= '0;
      q_bit    <= 1'b0;
      resp_bit <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], q_acc};
      if (q_acc) q_off <= bus.query_addr[OFF_W-1:0];
      q_bit    <= rd_q[q_off];
      resp_bit <= q_bit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_q <= mem[rd_addr];
  end

  // edge words of a range are partially masked, inner words fully
  always_comb begin
    lb = (wa == word_of(cur.low))  ? cur.low[OFF_W-1:0]  : '0;
    hb = (wa == word_of(cur.high)) ? cur.high[OFF_W-1:0] : '1;
    mask = '0;
    for (int i = 0; i < WORD_W; i++) mask[i] = (OFF_W'(i) >= lb) && (OFF_W'(i) <= hb);
    merged = cur.fresh ? (rd_q | mask) : (rd_q & ~mask);
  end

  always_comb begin
    popcnt = '0;
    for (int i = 0; i < WORD_W; i++) popcnt = popcnt + CNT_W'(rd_q[i]);
  end

  assign last_word = (state == S_FILL) ? word_of(cur.high) : WA_W'(NWORDS - 1);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_INIT;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    pop        = 1'b0;
    rd_en      = 1'b0;
    rd_addr    = ptr;
    wr_en      = 1'b0;
    wr_addr    = ptr;
    wr_data    = '0;
    finish_cnt = 1'b0;
    case (state)
      S_INIT: begin
        wr_en = 1'b1;
        if (ptr == WA_W'(NWORDS - 1)) state_nx = S_IDLE;
      end
      S_IDLE: begin
        if (q_acc) begin
          rd_en   = 1'b1;
          rd_addr = word_of(bus.query_addr);
        end
        if (pending && fifo_empty) state_nx = S_COUNT;
        else if (!fifo_empty) begin
          pop = 1'b1;
          if (head.low <= head.high) state_nx = S_FILL;
        end
      end
      S_FILL: begin
        rd_en   = !rd_done;
        wr_en   = wpend;
        wr_addr = wa;
        wr_data = merged;
        if (rd_done && !wpend) state_nx = S_IDLE;
      end
      S_COUNT: begin
        rd_en = !rd_done;
        if (rd_done && !wpend) begin
          state_nx   = S_IDLE;
          finish_cnt = 1'b1;
        end
      end
      default: state_nx = S_INIT;
    endcase
  end

  // ptr issues reads one word ahead; wa/wpend track the word sitting in rd_q
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr         <= '0;
      wa          <= '0;
      rd_done     <= 1'b0;
      wpend       <= 1'b0;
      cur         <= '0;
      acc         <= '0;
      pending     <= 1'b0;
      err_q       <= 1'b0;
      count_q     <= '0;
      count_vld_q <= 1'b0;
    end else begin
      count_vld_q <= finish_cnt;
      if (bus.cmd_count)   pending <= 1'b1;
      else if (finish_cnt) pending <= 1'b0;
      if (finish_cnt) count_q <= acc;
      wpend <= rd_en && (state != S_IDLE);
      wa    <= ptr;
      case (state)
        S_INIT: ptr <= ptr + 1'b1;
        S_IDLE: begin
          rd_done <= 1'b0;
          acc     <= '0;
          if (pop) begin
            cur <= head;
            ptr <= word_of(head.low);
            if (head.low > head.high) err_q <= 1'b1;
          end else begin
            ptr <= '0;
          end
        end
        default: begin
          if (rd_en) begin
            ptr <= ptr + 1'b1;
            if (ptr == last_word) rd_done <= 1'b1;
          end
          if (state == S_COUNT && wpend) acc <= acc + popcnt;
        end
      endcase
    end
  end

  assign bus.range_ready = rst_n && !fifo_full;
  assign bus.resp_valid  = vld_pipe[STAGES];
  assign bus.resp_fresh  = resp_bit;
  assign bus.count_valid = count_vld_q;
  assign bus.count_value = count_q;
  assign bus.busy        = (state != S_IDLE) || !fifo_empty;
  assign bus.err_order   = err_q;
endmodule

// File: tb/tb_fresh_bitmap_engine.sv
// Directed bench for fresh_bitmap_engine with a per-ID bitmap model and a per-cycle monitor.
module tb_fresh_bitmap_engine;
  localparam int ADDR_W = 8, WORD_W = 8, FIFO_DEPTH = 16, CNT_W = 9, NWORDS = 32, NIDS = 256;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fresh_bitmap_engine_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();
  fresh_bitmap_engine #(.ADDR_W(ADDR_W), .WORD_W(WORD_W), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct { int addr; int issue; bit exp; } q_t;

  int  checks = 0, failures = 0, cyc = 0, cv_pulses = 0;
  bit  model [NIDS];
  bit  model_err, cnt_pend;
  q_t  qq [$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int model_pop();
    int s = 0;
    for (int i = 0; i < NIDS; i++) s += int'(model[i]);
    return s;
  endfunction

  // monitor: handshakes seen here are accepted at the following rising edge
  always @(negedge clk) begin
    q_t e;
    cyc++;
    if (!rst_n) begin
      qq.delete();
      cnt_pend  = 1'b0;
      model_err = 1'b0;
      for (int i = 0; i < NIDS; i++) model[i] = 1'b0;
    end else begin
      if (bus.resp_valid) begin
        if (qq.size() == 0) chk("resp_spurious", 1, 0);
        else begin
          e = qq.pop_front();
          chk("resp_latency", cyc - e.issue, 3);
          chk($sformatf("resp_fresh[%0d]", e.addr), int'(bus.resp_fresh), int'(e.exp));
        end
      end else if (qq.size() != 0 && cyc - qq[0].issue > 3) begin
        chk("resp_missing", 0, 1);
        e = qq.pop_front();
      end
      if (bus.count_valid) begin
        cv_pulses++;
        chk("count_expected", int'(cnt_pend), 1);
        chk("count_value_model", int'(bus.count_value), model_pop());
        cnt_pend = 1'b0;
      end
      if (bus.cmd_count) cnt_pend = 1'b1;
      if (bus.query_valid && bus.query_ready)
        qq.push_back('{int'(bus.query_addr), cyc, model[bus.query_addr]});
      if (bus.range_valid && bus.range_ready) begin
        if (bus.range_low > bus.range_high) model_err = 1'b1;
        else for (int i = int'(bus.range_low); i <= int'(bus.range_high); i++) model[i] = bus.range_fresh;
      end
    end
  end

  // all driver tasks start and end 1ns after a rising edge
  task automatic push_range(input int lo, input int hi, input bit fr);
    bit was;
    int n = 0;
    bus.range_valid = 1'b1;
    bus.range_low   = ADDR_W'(lo);
    bus.range_high  = ADDR_W'(hi);
    bus.range_fresh = fr;
    forever begin
      @(negedge clk); was = bus.range_ready;
      @(posedge clk); #1;
      if (was) break;
      if (++n > 3000) begin chk("range_push_timeout", 0, 1); break; end
    end
    bus.range_valid = 1'b0;
  endtask

  task automatic q(input int a);
    bit was;
    int n = 0;
    bus.query_valid = 1'b1;
    bus.query_addr  = ADDR_W'(a);
    forever begin
      @(negedge clk); was = bus.query_ready;
      @(posedge clk); #1;
      if (was) break;
      if (++n > 3000) begin chk("query_timeout", 0, 1); break; end
    end
    bus.query_valid = 1'b0;
  endtask

  task automatic query_lit(input int a, input bit exp);
    q(a);
    @(posedge clk); @(posedge clk); @(negedge clk);
    chk($sformatf("lit_resp_valid[%0d]", a), int'(bus.resp_valid), 1);
    chk($sformatf("lit_resp_fresh[%0d]", a), int'(bus.resp_fresh), int'(exp));
    @(posedge clk); #1;
  endtask

  task automatic query_all();
    for (int a = 0; a < NIDS; a++) q(a);
    repeat (5) @(posedge clk);
    #1;
    chk("resp_queue_drained", qq.size(), 0);
  endtask

  task automatic wait_idle();
    int n = 0;
    forever begin
      @(negedge clk);
      if (!bus.busy && bus.query_ready) break;
      if (++n > 3000) begin chk("idle_timeout", 0, 1); break; end
    end
    chk("err_order_model", int'(bus.err_order), int'(model_err));
    @(posedge clk); #1;
  endtask

  task automatic count_lit(input int exp);
    int n = 0;
    bus.cmd_count = 1'b1;
    @(posedge clk); #1;
    bus.cmd_count = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.count_valid) break;
      if (++n > 3000) begin chk("count_timeout", 0, 1); break; end
    end
    chk("count_lit", int'(bus.count_value), exp);
    @(negedge clk);
    chk("count_valid_single", int'(bus.count_valid), 0);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.range_valid = 1'b0;
    bus.query_valid = 1'b0;
    bus.cmd_count   = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int n, cvb;
    bus.range_valid = 1'b0; bus.range_low = '0; bus.range_high = '0; bus.range_fresh = 1'b0;
    bus.query_valid = 1'b0; bus.query_addr = '0; bus.cmd_count = 1'b0;

    // reset values, then exact INIT length
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_range_ready", int'(bus.range_ready), 0);
    chk("rst_query_ready", int'(bus.query_ready), 0);
    chk("rst_resp_valid",  int'(bus.resp_valid), 0);
    chk("rst_resp_fresh",  int'(bus.resp_fresh), 0);
    chk("rst_count_valid", int'(bus.count_valid), 0);
    chk("rst_count_value", int'(bus.count_value), 0);
    chk("rst_err_order",   int'(bus.err_order), 0);
    chk("rst_busy",        int'(bus.busy), 1);
    @(posedge clk); #1 rst_n = 1'b1;
    n = 0;
    forever begin
      @(posedge clk); n++;
      @(negedge clk);
      if (n == 1) chk("range_ready_after_rst", int'(bus.range_ready), 1);
      if (bus.query_ready || n > 200) break;
    end
    chk("init_cycles", n, NWORDS);
    @(posedge clk); #1;
    query_all();

    // small range; queries must wait for the FIFO to drain
    push_range(3, 5, 1'b1);
    chk("query_held_off", int'(bus.query_ready), 0);
    query_lit(2, 1'b0); query_lit(3, 1'b1); query_lit(5, 1'b1); query_lit(6, 1'b0);

    // clear, paint, spoil a hole, count
    push_range(0, 255, 1'b0);
    push_range(5, 250, 1'b1);
    push_range(10, 20, 1'b0);
    count_lit(235);
    query_lit(9, 1'b1); query_lit(10, 1'b0); query_lit(20, 1'b0); query_lit(21, 1'b1);
    query_all();

    // 16 overlapping ranges queued during INIT; order decides the result
    do_reset();
    for (int k = 0; k < 16; k++) push_range(k * 10, k * 10 + 30, (k % 2) == 0);
    chk("fifo_full_ready", int'(bus.range_ready), 0);
    n = 16;
    forever begin
      @(posedge clk); n++;
      @(negedge clk);
      if (bus.range_ready || n > 200) break;
    end
    chk("ready_recovers_cycle", n, NWORDS + 1);
    @(posedge clk); #1;
    wait_idle();
    query_lit(0, 1'b1); query_lit(31, 1'b0); query_lit(180, 1'b0); query_lit(160, 1'b0);
    query_all();
    count_lit(model_pop());

    // bad-order range, empty count, merged count requests during FILL
    do_reset();
    wait_idle();
    push_range(9, 4, 1'b1);
    wait_idle();
    chk("err_order_lit", int'(bus.err_order), 1);
    count_lit(0);
    push_range(0, 255, 1'b1);
    cvb = cv_pulses;
    repeat (3) begin
      bus.cmd_count = 1'b1; @(posedge clk); #1;
      bus.cmd_count = 1'b0; @(posedge clk); #1;
    end
    n = 0;
    while (cv_pulses == cvb && n < 500) begin @(posedge clk); n++; end
    #1;
    chk("full_map_count", int'(bus.count_value), 256);
    repeat (60) @(posedge clk);
    #1;
    chk("merged_count_pulses", cv_pulses - cvb, 1);
    wait_idle();

    // reset in the middle of a full-map FILL
    push_range(0, 255, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    do_reset();
    wait_idle();
    chk("post_abort_count_value", int'(bus.count_value), 0);
    chk("post_abort_err", int'(bus.err_order), 0);
    query_all();
    count_lit(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/fresh_bitmap_engine.md
# fresh_bitmap_engine

Parametrised successor to the single-bit fresh-ingredient identifier. Ingredient ID ranges are buffered in an internal synchronous FIFO and painted into a word-wide bitmap RAM, WORD_W IDs per cycle. Single-ID freshness queries run over a pipelined valid/ready port. A count command sweeps the bitmap and reports the total number of fresh IDs. The block sits in the main `clk` domain; any clock crossing is done upstream.

## Interface
- ADDR_W, 17, ID width; the bitmap covers 2^ADDR_W IDs.
- WORD_W, 32, bits per RAM word; power of 2, 2..2^ADDR_W. NWORDS = 2^ADDR_W / WORD_W.
- FIFO_DEPTH, 16, range FIFO entries; power of 2 ≥ 2.
- CNT_W, ADDR_W+1, width of the fresh-count result.
- clk  in  1  Single clock; all logic on its rising edge.
- rst_n  in  1  Reset, synchronous, active-low.
- range_valid  in  1  Range offered.
- range_ready  out  1  FIFO not full; a transfer occurs when valid & ready.
- range_low, range_high  in  ADDR_W each  Inclusive ID bounds.
- range_fresh  in  1  1 = set bits (fresh), 0 = clear bits (spoiled).
- query_valid / query_ready  in / out  1  Query handshake.
- query_addr  in  ADDR_W  ID to check.
- resp_valid  out  1  One-cycle pulse per accepted query.
- resp_fresh  out  1  Bitmap bit for that query; valid only with resp_valid.
- cmd_count  in  1  Pulse; requests a fresh-count sweep.
- count_valid  out  1  One-cycle pulse when count_value updates.
- count_value  out  CNT_W  Last completed count; held until the next completion.
- busy  out  1  High in INIT, FILL and COUNT, or while the FIFO is non-empty.
- err_order  out  1  Sticky; set when a range with low > high is accepted. Cleared only by reset.

## Operation
- States: INIT, IDLE, FILL, COUNT.
- INIT (entered on reset): writes zero to words 0..NWORDS-1, one word per cycle, then goes to IDLE. The FIFO accepts ranges during INIT.
- IDLE, in priority order:
  - Pending count request and FIFO empty: go to COUNT.
  - FIFO non-empty: pop one entry. If low > high, drop it (set err_order) and stay in IDLE. Otherwise go to FILL.
- FILL: for each word k from low>>log2(WORD_W) to high>>log2(WORD_W):
  - Read-modify-write. mask = ones from (k==lo word ? low%WORD_W : 0) to (k==hi word ? high%WORD_W : WORD_W-1).
  - New word = fresh ? old|mask : old&~mask.
  - Reads are pipelined one word ahead of writes, giving one word per cycle. Consecutive words never alias.
- COUNT: read all NWORDS words and accumulate popcount into a CNT_W accumulator. Then load count_value, pulse count_valid, clear the pending flag and return to IDLE. The full-bitmap count is 2^ADDR_W and must fit in CNT_W without wrap.
- cmd_count in any state sets a pending flag. Repeated requests before service merge into one sweep. The count therefore reflects every range accepted before the sweep starts.
- Ranges accepted during COUNT stay in the FIFO until the sweep finishes.
- query_ready = (state==IDLE) & FIFO empty & !pending count. Queries never observe a partially painted range.

## Timing
- Reset values:
  - range_ready=0 while rst_n=0, then 1.
  - query_ready=0, resp_valid=0, resp_fresh=0, count_valid=0, count_value=0, err_order=0, busy=1.
  - State=INIT. FIFO empty.
- INIT lasts NWORDS cycles. query_ready first rises on cycle NWORDS+1 after rst_n rises, provided no ranges were accepted.
- Query latency is 2 cycles: accepted at edge t, resp_valid at edge t+2. One query per cycle sustained. resp_valid has no backpressure.
- Range pop at edge t spanning W words: writes land on edges t+2..t+W+1. The state is back in IDLE at t+W+2. A bad-order pop costs 1 cycle.
- FIFO: range_ready = !full. A push into a full FIFO is impossible by handshake. A simultaneous push and pop on a full FIFO is not allowed, because ready is already low.
- COUNT takes NWORDS+2 cycles from entry to the count_valid pulse.
- rst_n low in any state: abort at the next edge. FIFO is flushed, the pending count is dropped, and an in-flight FILL is discarded. The block then restarts INIT.

## Test plan
- ADDR_W=8, WORD_W=8: release reset, then query IDs 0..255 once query_ready rises -> ready after exactly 32 INIT cycles; all resp_fresh=0; each resp_valid 2 cycles after its handshake.
- Range 3..5 fresh, then queries of 2, 3, 5, 6 -> responses 0, 1, 1, 0; queries held off until the FIFO drains.
- Range 5..250 fresh, range 10..20 spoiled, cmd_count -> count_value=235, count_valid a single pulse; 11 spoiled IDs read 0.
- Push 16 ranges back-to-back during INIT -> range_ready falls after entry 16 and recovers one cycle after the first pop; all 16 are applied in order.
- Range 9..4 fresh -> err_order=1, bitmap unchanged; count of an empty map = 0; cmd_count pulsed 3 times during a FILL -> exactly one count_valid pulse.
- Assert rst_n=0 mid-FILL of 0..255 -> after reset and INIT, all queries return 0 and count_value=0.
